// File: rtl/fib_stack_sequencer.sv
// Start-to-done sequencer: computes Fibonacci terms, pushes them onto the external stack, then pops them back onto v0.
// Optional build macro FIB_SATURATE_EN: overflowing terms clamp to all-ones for the rest of the run instead of wrapping.
module fib_stack_sequencer #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_button,
    input  logic             start,
    input  logic [7:0]       a0_init,
    input  logic [WIDTH-1:0] stack_val_out,
    output logic [AW-1:0]    stack_addr,
    output logic [WIDTH-1:0] stack_val_in,
    output logic             push_en,
    output logic             pop_en,
    output logic             active_en,
    output logic [WIDTH-1:0] v0,
    output logic             v0_valid,
    output logic             done,
    output logic             overflow
);

    typedef enum logic [2:0] {IDLE, PUSH, POP, DRAIN1, DRAIN2, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] cur;
    logic             cur_ovf;
    logic [AW-1:0]    n_last;
    logic             pop_d1;

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] next_cur;
    logic             next_ovf;
    logic [AW-1:0]    start_last;

    always_comb begin
        sum_ext = {1'b0, prev} + {1'b0, cur};
`ifdef FIB_SATURATE_EN
        next_ovf = sum_ext[WIDTH] | cur_ovf;
        next_cur = next_ovf ? '1 : sum_ext[WIDTH-1:0];
`else
        next_ovf = sum_ext[WIDTH];
        next_cur = sum_ext[WIDTH-1:0];
`endif
        start_last = ({24'b0, a0_init} >= 32'(DEPTH)) ? AW'(DEPTH - 1) : AW'(a0_init - 8'd1);
    end

    always_ff @(posedge clk) begin
        if (!reset_button) begin
            state        <= IDLE;
            prev         <= '0;
            cur          <= '0;
            cur_ovf      <= 1'b0;
            n_last       <= '0;
            pop_d1       <= 1'b0;
            stack_addr   <= '0;
            stack_val_in <= '0;
            push_en      <= 1'b0;
            pop_en       <= 1'b0;
            active_en    <= 1'b0;
            v0           <= '0;
            v0_valid     <= 1'b0;
            done         <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            // Read data arrives the cycle after pop_en; v0 registers it one cycle later.
            pop_d1   <= pop_en;
            v0_valid <= pop_d1;
            if (pop_d1)
                v0 <= stack_val_out;

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        overflow     <= 1'b0;
                        prev         <= '0;
                        cur          <= WIDTH'(1);
                        cur_ovf      <= 1'b0;
                        n_last       <= start_last;
                        stack_addr   <= '0;
                        stack_val_in <= '0;
                        if (a0_init == 8'd0) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            active_en <= 1'b0;
                        end else begin
                            state     <= PUSH;
                            done      <= 1'b0;
                            active_en <= 1'b1;
                            push_en   <= 1'b1;
                        end
                    end
                end
                PUSH: begin
                    if (stack_addr == n_last) begin
                        state        <= POP;
                        push_en      <= 1'b0;
                        pop_en       <= 1'b1;
                        stack_val_in <= '0;
                    end else begin
                        // overflow is flagged when an overflowed term is actually pushed
                        stack_addr   <= stack_addr + 1'b1;
                        stack_val_in <= cur;
                        prev         <= cur;
                        cur          <= next_cur;
                        cur_ovf      <= next_ovf;
                        if (cur_ovf)
                            overflow <= 1'b1;
                    end
                end
                POP: begin
                    if (stack_addr == '0) begin
                        state  <= DRAIN1;
                        pop_en <= 1'b0;
                    end else begin
                        stack_addr <= stack_addr - 1'b1;
                    end
                end
                DRAIN1: state <= DRAIN2;
                DRAIN2: begin
                    state     <= DONE;
                    done      <= 1'b1;
                    active_en <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fib_stack_sequencer.sv
// Self-checking bench: behavioural stack, table of runs, scoreboard queues for pushes, pops and v0.
module tb_fib_stack_sequencer;

    localparam int DEPTH = 32;
    localparam int WIDTH = 8;
    localparam int AW = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             reset_button = 1'b0;
    logic             start = 1'b0;
    logic [7:0]       a0_init = 8'd0;
    logic [WIDTH-1:0] stack_val_out = '0;
    logic [AW-1:0]    stack_addr;
    logic [WIDTH-1:0] stack_val_in;
    logic             push_en, pop_en, active_en, v0_valid, done, overflow;
    logic [WIDTH-1:0] v0;

    fib_stack_sequencer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .reset_button(reset_button), .start(start), .a0_init(a0_init),
        .stack_val_out(stack_val_out), .stack_addr(stack_addr), .stack_val_in(stack_val_in),
        .push_en(push_en), .pop_en(pop_en), .active_en(active_en), .v0(v0),
        .v0_valid(v0_valid), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (push_en) mem[stack_addr] <= stack_val_in;
        if (pop_en)  stack_val_out <= mem[stack_addr];
    end

    int total = 0;
    int bad = 0;
    int exp_pa[$], exp_pv[$], exp_qa[$], exp_v0[$];
    int first_v0;
    bit first_seen;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("push_pop_exclusive", int'(push_en & pop_en), 0);
        if (push_en) begin
            if (exp_pa.size() == 0) check("unexpected_push", 1, 0);
            else begin
                check("push_addr", int'(stack_addr), exp_pa.pop_front());
                check("push_val", int'(stack_val_in), exp_pv.pop_front());
            end
        end
        if (pop_en) begin
            if (exp_qa.size() == 0) check("unexpected_pop", 1, 0);
            else check("pop_addr", int'(stack_addr), exp_qa.pop_front());
        end
        if (v0_valid) begin
            if (!first_seen) begin
                first_seen = 1'b1;
                first_v0 = int'(v0);
            end
            if (exp_v0.size() == 0) check("unexpected_v0", 1, 0);
            else check("v0_value", int'(v0), exp_v0.pop_front());
        end
    end

    // Independent Fibonacci model: wraps or saturates per build, loads all expectation queues.
    task automatic load_model(input int a0);
        int n, t[DEPTH], s;
        bit sat;
        n = (a0 > DEPTH) ? DEPTH : a0;
        sat = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (k < 2) t[k] = k;
            else begin
                s = t[k-1] + t[k-2];
`ifdef FIB_SATURATE_EN
                if (s > 255 || sat) begin s = 255; sat = 1'b1; end
`else
                s = s % 256;
`endif
                t[k] = s;
            end
            exp_pa.push_back(k);
            exp_pv.push_back(t[k]);
        end
        for (int k = n - 1; k >= 0; k--) begin
            exp_qa.push_back(k);
            exp_v0.push_back(t[k]);
        end
    endtask

    task automatic run(input int a0, input int exp_lat, input int exp_ovf, input int glitch, input int exp_first);
        int lat;
        load_model(a0);
        first_seen = 1'b0;
        @(negedge clk);
        a0_init = 8'(a0);
        start = 1'b1;
        @(posedge clk);
        lat = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            start = (c == glitch);
            if (done) begin
                lat = c;
                break;
            end
        end
        start = 1'b0;
        check($sformatf("done_latency_n%0d", a0), lat, exp_lat);
        check($sformatf("overflow_n%0d", a0), int'(overflow), exp_ovf);
        check($sformatf("v0_at_done_n%0d", a0), int'(v0), 0);
        check($sformatf("active_at_done_n%0d", a0), int'(active_en), 0);
        check($sformatf("queues_drained_n%0d", a0),
              exp_pa.size() + exp_qa.size() + exp_v0.size(), 0);
        if (exp_first >= 0)
            check($sformatf("first_v0_n%0d", a0), first_seen ? first_v0 : -1, exp_first);
    endtask

    typedef struct {
        int a0;
        int lat;
        int ovf;
        int glitch;
        int first;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{a0: 7,  lat: 17, ovf: 0, glitch: 0, first: 8};
        vecs[1] = '{a0: 0,  lat: 1,  ovf: 0, glitch: 0, first: -1};
`ifdef FIB_SATURATE_EN
        vecs[2] = '{a0: 15, lat: 33, ovf: 1, glitch: 0, first: 255};
`else
        vecs[2] = '{a0: 15, lat: 33, ovf: 1, glitch: 0, first: 121};
`endif
        vecs[3] = '{a0: 40, lat: 67, ovf: 1, glitch: 0, first: -1};
        vecs[4] = '{a0: 1,  lat: 5,  ovf: 0, glitch: 0, first: 0};
        vecs[5] = '{a0: 2,  lat: 7,  ovf: 0, glitch: 0, first: 1};
        vecs[6] = '{a0: 7,  lat: 17, ovf: 0, glitch: 3, first: 8};

        repeat (3) @(negedge clk);
        check("reset_outputs", int'({stack_addr, stack_val_in, v0, push_en, pop_en,
                                     active_en, v0_valid, done, overflow}), 0);
        reset_button = 1'b1;

        for (int i = 0; i < 7; i++)
            run(vecs[i].a0, vecs[i].lat, vecs[i].ovf, vecs[i].glitch, vecs[i].first);

        // Reset during the third pop of an N=7 run.
        load_model(7);
        @(negedge clk);
        a0_init = 8'd7;
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("third_pop_addr", int'({pop_en, stack_addr}), int'({1'b1, 5'd4}));
        reset_button = 1'b0;
        @(posedge clk);
        exp_pa.delete(); exp_pv.delete(); exp_qa.delete(); exp_v0.delete();
        @(negedge clk);
        check("midrun_reset_outputs", int'({stack_addr, stack_val_in, v0, push_en, pop_en,
                                            active_en, v0_valid, done, overflow}), 0);
        reset_button = 1'b1;
        run(3, 9, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fib_stack_sequencer.md
# fib_stack_sequencer

Controller that sequences the Fibonacci ASIC datapath: it computes Fibonacci terms with an internal WIDTH-bit adder, pushes them into the external `stack_register`, then pops them back out in reverse order onto `v0`. It replaces the hand-driven push/pop/active enables with one start-to-done run. It sits between `top_level_asic`'s `a0_init`/`done` interface and the `stack_register` instance.

## Interface
Parameters:
- `DEPTH`, 32: stack entries; run length clamps to this.
- `WIDTH`, 8: data width of terms and stack values.

Ports (AW = $clog2(DEPTH)):
- `clk`  in  1  clock; all logic on rising edge.
- `reset_button`  in  1  synchronous, active-low reset.
- `start`  in  1  begin a run; sampled in IDLE and DONE only.
- `a0_init`  in  8  requested term count N.
- `stack_val_out`  in  WIDTH  stack read data; valid the cycle after `pop_en`.
- `stack_addr`  out  AW  stack address.
- `stack_val_in`  out  WIDTH  stack write data.
- `push_en`  out  1  stack write strobe.
- `pop_en`  out  1  stack read strobe.
- `active_en`  out  1  high in every state except IDLE and DONE.
- `v0`  out  WIDTH  popped term; holds its last value.
- `v0_valid`  out  1  one-cycle pulse per new `v0`.
- `done`  out  1  run complete; high in DONE.
- `overflow`  out  1  sticky per run: some term exceeded 2^WIDTH-1.

## Operation
- States: IDLE, PUSH, POP, DRAIN1, DRAIN2, DONE.
- Reset (`reset_button`=0 at an edge) goes to IDLE. All outputs are 0, and the term registers, counters and `overflow` are cleared. Reset wins over `start`. A reset mid-run abandons the run, so no push or pop occurs in the following cycle.
- IDLE/DONE with `start`=1: latch N = min(`a0_init`, DEPTH), clear `overflow`, load prev=0 and cur=1.
  - N=0: go directly to DONE.
  - Otherwise: go to PUSH with k=0.
- PUSH, cycle k (k = 0..N-1): `push_en`=1, `stack_addr`=k, `stack_val_in`=F(k), where F(0)=0, F(1)=1, F(k)=F(k-1)+F(k-2). The next term is computed each cycle as prev+cur. After k=N-1, go to POP with `stack_addr`=N-1.
- POP: `pop_en`=1 and `stack_addr` decrements from N-1 to 0, one per cycle. After the address-0 pop, go to DRAIN1.
- `v0` is registered from `stack_val_out` one cycle after read data is valid. `v0_valid` pulses 2 cycles after the corresponding pop.
- DRAIN1 then DRAIN2: no strobes. These cycles flush the last two `v0` values. Then go to DONE.
- DONE: `done`=1. `v0` holds F(0), or 0 if N=0. Stays in DONE until `start` launches a new run.
- `start` in PUSH/POP/DRAIN is ignored.
- Arithmetic: unsigned WIDTH-bit. A sum ≥ 2^WIDTH sets `overflow`, which stays set until the next start or reset. Default behaviour wraps mod 2^WIDTH.
- `push_en` and `pop_en` are never high in the same cycle.

## Timing
- `start` sampled at edge t. First push is in cycle t+1. Pushes occupy t+1..t+N, pops t+N+1..t+2N.
- `v0_valid` is high in cycles t+N+3..t+2N+2.
- `done` rises in cycle t+2N+3.
- N=0: `done` high in cycle t+1, no strobes.
- Re-run from DONE: `done` drops in cycle t+1 of the new run.

## Configuration
- `FIB_SATURATE_EN` defined: an overflowing sum clamps to 2^WIDTH-1, and every later term in the run also stays clamped. `overflow` is still set.
- Undefined: sums wrap mod 2^WIDTH.

## Test plan
- Reset, then `a0_init`=7, `start` pulse:
  - Pushes 0,1,1,2,3,5,8 at addresses 0..6.
  - `v0` sequence 8,5,3,2,1,1,0.
  - `done` at t+17; `overflow`=0.
- `a0_init`=0, `start` → no push/pop, `done` at t+1, `v0`=0.
- `a0_init`=15:
  - Term 14 is 121 (wrap), or 255 with `FIB_SATURATE_EN`.
  - `overflow`=1 and first `v0`=121 or 255.
- `a0_init`=40 → clamps to 32 (pops at addresses 31..0), `done` at t+67, `overflow`=1.
- `start` pulsed during PUSH of an N=7 run → ignored; identical output and `done` at t+17.
- `reset_button`=0 in 3rd POP cycle → next cycle all outputs 0, IDLE. A new N=3 run then yields `v0` sequence 1,1,0.
